seven_seg_scan_mux: RTL and testbench
=====================================

// Module: seven_seg_scan_mux
// PURPOSE
//  Parametrised 7-segment scan driver; successor to the fixed 4-digit two-field display driver.
//  - Each field is a binary value 0..99 and is shown as two decimal digits.
//  - Time-multiplexes NUM_DIGITS common-anode digits and adds:
//    anti-ghost blanking, frame-coherent input capture, decimal points, leading-zero blanking, blink.
//  - Sits between the clock/alarm time registers and the board SEG/AN pins.
// PARAMETERS
//  NUM_DIGITS    4      digit count; even, 2..8; NUM_FIELDS = NUM_DIGITS/2
//  FIELD_W       7      bits per binary field
//  SCAN_DIV      50000  CLK cycles per digit slot (>= BLANK_CYC+2)
//  BLANK_CYC     16     cycles at slot start with all anodes off
//  BLINK_FRAMES  128    frames per blink half-period (BLINK_EN only)
// PORTS
//  CLK         in   1                   clock
//  RST_N       in   1                   synchronous reset, active-low
//  EN          in   1                   display enable
//  VAL         in   NUM_FIELDS*FIELD_W  packed fields; field k = VAL[k*FIELD_W +: FIELD_W]
//  DP_MASK     in   NUM_DIGITS          1 = light decimal point of digit i
//  LZB         in   1                   1 = blank the tens digit of any field < 10
//  BLINK_MASK  in   NUM_FIELDS          1 = field k blinks (BLINK_EN only)
//  SEG         out  7                   {a,b,c,d,e,f,g}, active-low
//  DP          out  1                   decimal point, active-low
//  AN          out  NUM_DIGITS          anodes, active-low; AN[0] = rightmost digit
// BEHAVIOUR
//  Reset (RST_N=0 at posedge CLK): SEG=7'h7F, DP=1, AN=all 1s; idx, prescaler, frame counter, blink phase and shadow = 0.
//  Digit mapping: digit 2k = units of field k; digit 2k+1 = tens of field k.
//  Prescaler: pcnt counts 0..SCAN_DIV-1.
//   - At pcnt==SCAN_DIV-1, idx advances and wraps NUM_DIGITS-1 -> 0.
//   - The wrap is the frame end.
//  Slot output:
//   - pcnt < BLANK_CYC: AN all 1s, SEG=7F, DP=1.
//   - Otherwise: AN[idx]=0, others 1; SEG/DP = decode of digit idx.
//  Outputs are registered; pins reflect the pcnt/idx state of the previous cycle (1-cycle latency).
//  Shadow register:
//   - Loads VAL and DP_MASK on the frame-end cycle, and every cycle while EN=0.
//   - Decode uses only the shadow, so there is no tearing within a frame.
//  Decode:
//   - Digits 0..9 use the standard table (0 -> 7'b0000001 ... 9 -> 7'b0000100).
//   - Field value > 99: both of its digits show dash SEG=7'b1111110.
//   - Field value >= 2^FIELD_W cannot occur. If FIELD_W < 7, zero-extend.
//   - LZB=1 and field < 10: tens digit SEG=7F. The DP of that digit still follows DP_MASK.
//  EN=0:
//   - AN all 1s, SEG=7F, DP=1 from the next cycle.
//   - Prescaler, idx and blink keep running.
//  Deassert/assert of EN mid-slot: takes effect the next cycle; no realignment of idx.
//  Reset mid-slot: everything returns to reset values on the next edge; the scan restarts at idx 0.
// CONFIGURATION
//  Macro SEVEN_SEG_BLINK_EN.
//  Defined:
//   - BLINK_MASK port exists.
//   - The frame counter toggles blink phase every BLINK_FRAMES frames.
//   - Phase=1: digits of fields with a BLINK_MASK bit set output SEG=7F, DP=1; the AN pattern is unchanged.
//  Undefined:
//   - BLINK_MASK port, frame counter and phase are absent; no digit ever blinks.
// STRUCTURE
//  Package seven_seg_pkg holds:
//   - SEG_BLANK=7'h7F, SEG_DASH=7'b1111110.
//   - Function seg_decode(4-bit) -> 7-bit active-low.
//   - Function clog2-based width helpers.
//  Sub-module bin_to_2digit, instantiated NUM_FIELDS times:
//   - Combinational FIELD_W binary -> {tens,units} 4-bit plus ovf (>99).
//  Top holds prescaler, idx, shadow, blink and output registers.
// TESTING  (sim params: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
//  1 Reset with RST_N=0 for 3 cycles -> SEG=7F, DP=1, AN=4'b1111 on every cycle; after release, first AN=4'b1110 at cycle 3.
//  2 Scan with VAL={7'd12,7'd34}, EN=1 -> slots show units 4, tens 3, units 2, tens 1 on AN 1110/1101/1011/0111.
//    Each slot: 2 blank cycles, then 6 lit cycles. SEG for "4" = 7'b1001100.
//  3 Frame coherence: change VAL to {7'd56,7'd78} mid-frame -> the remaining slots still show 12/34; the next frame shows 56/78.
//  4 Boundaries:
//   - VAL field0=7'd5 with LZB=1 -> digit1 SEG=7F, digit0 = "5".
//   - Field1=7'd120 -> digits 2,3 both SEG=7'b1111110.
//   - Field0=0 with LZB=1 -> digit0 = "0", digit1 blank.
//   - DP_MASK=4'b0100 -> DP=0 only while AN=4'b1011.
//  5 EN toggle: EN=0 mid-slot -> AN=1111 next cycle; EN=1 -> resumes at the current idx with no realignment.
//  6 SEVEN_SEG_BLINK_EN with BLINK_MASK=2'b10 -> digits 2,3 are blank in alternate 2-frame periods; digits 0,1 are always lit.
//    Without the macro, the same stimulus leaves every digit always lit.

Source files
------------

// File: rtl/seven_seg_scan_mux_pkg.sv
// Shared constants, segment decode table and counter-width helpers for the
// multiplexed 7-segment scan driver.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // {a,b,c,d,e,f,g}, active-low; non-decimal codes come out blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_scan_mux_if.sv
// Display-side bundle: field values and display controls in, SEG/DP/AN pins out.
// BLINK_MASK exists only when SEVEN_SEG_BLINK_EN is defined.
interface seven_seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4,
  parameter int FIELD_W    = 7
);
  localparam int NUM_FIELDS = NUM_DIGITS / 2;

  logic                          EN;
  logic [NUM_FIELDS*FIELD_W-1:0] VAL;
  logic [NUM_DIGITS-1:0]         DP_MASK;
  logic                          LZB;
`ifdef SEVEN_SEG_BLINK_EN
  logic [NUM_FIELDS-1:0]         BLINK_MASK;
`endif
  logic [6:0]                    SEG;
  logic                          DP;
  logic [NUM_DIGITS-1:0]         AN;

`ifdef SEVEN_SEG_BLINK_EN
  modport master (output EN, VAL, DP_MASK, LZB, BLINK_MASK, input SEG, DP, AN);
  modport slave  (input EN, VAL, DP_MASK, LZB, BLINK_MASK, output SEG, DP, AN);
`else
  modport master (output EN, VAL, DP_MASK, LZB, input SEG, DP, AN);
  modport slave  (input EN, VAL, DP_MASK, LZB, output SEG, DP, AN);
`endif

endinterface

// File: rtl/seven_seg_scan_mux_bin_to_2digit.sv
// Combinational split of a binary field into decimal tens/units, flagging
// values above 99 so the caller can show dashes instead.
module bin_to_2digit #(
  parameter int FIELD_W = 7
) (
  input  logic [FIELD_W-1:0] bin,
  output logic [3:0]         tens,
  output logic [3:0]         units,
  output logic               ovf
);
  localparam int EXT_W = (FIELD_W > 7) ? FIELD_W : 7;

  logic [EXT_W-1:0] v;

  assign v     = EXT_W'(bin);
  assign ovf   = v > EXT_W'(99);
  // Digits are meaningless when ovf is set; the decoder ignores them then.
  assign tens  = 4'(v / EXT_W'(10));
  assign units = 4'(v % EXT_W'(10));

endmodule

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with blanking slots, frame-coherent
// capture, DP, leading-zero blanking and optional blink (SEVEN_SEG_BLINK_EN).
module seven_seg_scan_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int FIELD_W      = 7,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 128
) (
  input logic                CLK,
  input logic                RST_N,
  seven_seg_scan_mux_if.slave bus
);
  localparam int NUM_FIELDS = NUM_DIGITS / 2;
  localparam int PCNT_W     = cnt_w(SCAN_DIV);
  localparam int IDX_W      = cnt_w(NUM_DIGITS);

  if ((NUM_DIGITS % 2) != 0 || NUM_DIGITS < 2 || NUM_DIGITS > 8 ||
      SCAN_DIV < BLANK_CYC + 2 || BLINK_FRAMES < 1) begin : g_param_check
    $error("seven_seg_scan_mux: illegal parameter combination");
  end

  logic [PCNT_W-1:0]             pcnt_reg;
  logic [IDX_W-1:0]              idx_reg;
  logic [NUM_FIELDS*FIELD_W-1:0] val_shadow_reg;
  logic [NUM_DIGITS-1:0]         dp_shadow_reg;
  logic [6:0]                    seg_reg, seg_next;
  logic                          dp_reg, dp_next;
  logic [NUM_DIGITS-1:0]         an_reg, an_next;
  logic                          slot_end, frame_end;
  logic [6:0]                    digit_seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]         digit_blank;

  assign slot_end  = pcnt_reg == PCNT_W'(SCAN_DIV - 1);
  assign frame_end = slot_end && (idx_reg == IDX_W'(NUM_DIGITS - 1));

  // Decode works only from the shadow, so a frame never mixes old and new values.
  genvar gi;
  for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    logic [3:0] tens, units;
    logic       ovf;

    bin_to_2digit #(.FIELD_W(FIELD_W)) u_b2d (
      .bin   (val_shadow_reg[gi*FIELD_W +: FIELD_W]),
      .tens  (tens),
      .units (units),
      .ovf   (ovf)
    );

    assign digit_seg[2*gi]   = ovf ? SEG_DASH : seg_decode(units);
    assign digit_seg[2*gi+1] = ovf ? SEG_DASH :
                               (bus.LZB && tens == 4'd0) ? SEG_BLANK : seg_decode(tens);
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int FRAME_W = cnt_w(BLINK_FRAMES);
  logic [FRAME_W-1:0] frame_cnt_reg;
  logic               phase_reg;

  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blink
    assign digit_blank[gi] = phase_reg & bus.BLINK_MASK[gi/2];
  end
`else
  assign digit_blank = '0;
`endif

  always_comb begin
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    an_next  = '1;
    if (bus.EN && pcnt_reg >= PCNT_W'(BLANK_CYC)) begin
      an_next = ~(NUM_DIGITS'(1) << idx_reg);
      if (!digit_blank[idx_reg]) begin
        seg_next = digit_seg[idx_reg];
        dp_next  = ~dp_shadow_reg[idx_reg];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pcnt_reg       <= '0;
      idx_reg        <= '0;
      val_shadow_reg <= '0;
      dp_shadow_reg  <= '0;
      seg_reg        <= SEG_BLANK;
      dp_reg         <= 1'b1;
      an_reg         <= '1;
`ifdef SEVEN_SEG_BLINK_EN
      frame_cnt_reg  <= '0;
      phase_reg      <= 1'b0;
`endif
    end else begin
      pcnt_reg <= slot_end ? '0 : pcnt_reg + PCNT_W'(1);
      if (slot_end) begin
        idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end
      if (frame_end || !bus.EN) begin
        val_shadow_reg <= bus.VAL;
        dp_shadow_reg  <= bus.DP_MASK;
      end
`ifdef SEVEN_SEG_BLINK_EN
      if (frame_end) begin
        if (frame_cnt_reg == FRAME_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_reg <= '0;
          phase_reg     <= ~phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
        end
      end
`endif
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      an_reg  <= an_next;
    end
  end

  assign bus.SEG = seg_reg;
  assign bus.DP  = dp_reg;
  assign bus.AN  = an_reg;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Self-checking bench for seven_seg_scan_mux against a time-arithmetic reference model.
`timescale 1ns/1ps
module tb_seven_seg_scan_mux;
  localparam int ND    = 4;
  localparam int FW    = 7;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = SD * ND;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  seven_seg_scan_mux_if #(.NUM_DIGITS(ND), .FIELD_W(FW)) bus ();

  seven_seg_scan_mux #(
    .NUM_DIGITS(ND), .FIELD_W(FW), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  // Model: t = cycles since reset release; slot, digit and frame follow by division.
  int              t     = 0;
  int              t_pre = 0;
  logic [2*FW-1:0] sh_val = '0;
  logic [ND-1:0]   sh_dp  = '0;
  logic [6:0]      exp_seg;
  logic            exp_dp;
  logic [ND-1:0]   exp_an;

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input int v, input int is_tens, input logic lzb);
    if (v > 99) return 7'b1111110;
    if (is_tens == 0) return dec(v % 10);
    if (lzb && v < 10) return 7'h7F;
    return dec(v / 10);
  endfunction

  // Predict the pins after the coming edge, then advance DUT and model together.
  task automatic tick();
    int pc, ix, v;
    logic hide, load;
    logic [2*FW-1:0] nv;
    logic [ND-1:0]   nd;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    exp_an  = '1;
    t_pre   = t;
    if (RST_N !== 1'b1) begin
      @(posedge CLK); #1;
      t = 0; sh_val = '0; sh_dp = '0;
    end else begin
      pc = t % SD;
      ix = (t / SD) % ND;
      if (bus.EN && pc >= BC) begin
        exp_an[ix] = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
        hide = (((t / FRAME) / BF) % 2 == 1) && bus.BLINK_MASK[ix/2];
`else
        hide = 1'b0;
`endif
        if (!hide) begin
          v = int'(sh_val[(ix/2)*FW +: FW]);
          exp_seg = ref_seg(v, ix % 2, bus.LZB);
          exp_dp  = ~sh_dp[ix];
        end
      end
      load = !bus.EN || (t % FRAME == FRAME - 1);
      nv = load ? bus.VAL : sh_val;
      nd = load ? bus.DP_MASK : sh_dp;
      @(posedge CLK); #1;
      sh_val = nv; sh_dp = nd; t = t + 1;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; bus.EN = 1'b1; bus.VAL = {7'd12, 7'd34}; bus.DP_MASK = '0; bus.LZB = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
    bus.BLINK_MASK = '0;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({bus.SEG, bus.DP, bus.AN} !== {7'h7F, 1'b1, 4'hF}) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d seg/dp/an got=%b/%b/%b want=1111111/1/1111", i, bus.SEG, bus.DP, bus.AN);
      end
    end
    RST_N = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if ({bus.SEG, bus.DP, bus.AN} !== {exp_seg, exp_dp, exp_an}) begin
        bad++;
        $display("FAIL reset_release t=%0d seg/dp/an got=%b/%b/%b want=%b/%b/%b", t_pre, bus.SEG, bus.DP, bus.AN, exp_seg, exp_dp, exp_an);
      end
    end
    total++;
    if (bus.AN !== 4'b1110) begin
      bad++;
      $display("FAIL reset_first_an got=%b want=1110", bus.AN);
    end
    $display("[reset] done, checks so far=%0d", total);
  endtask

  task automatic test_scan();
    logic [15:0] digs;
    int pc, ix;
    digs = 16'h1234;
    while (t < 2 * FRAME) begin
      tick();
      total++;
      if ({bus.SEG, bus.DP, bus.AN} !== {exp_seg, exp_dp, exp_an}) begin
        bad++;
        $display("FAIL scan t=%0d seg/dp/an got=%b/%b/%b want=%b/%b/%b", t_pre, bus.SEG, bus.DP, bus.AN, exp_seg, exp_dp, exp_an);
      end
      pc = t_pre % SD; ix = (t_pre / SD) % ND;
      if (t_pre >= FRAME && pc >= BC) begin
        total++;
        if (bus.SEG !== dec(int'(digs[ix*4 +: 4]))) begin
          bad++;
          $display("FAIL scan_digit t=%0d idx=%0d got=%b want=%b", t_pre, ix, bus.SEG, dec(int'(digs[ix*4 +: 4])));
        end
      end
    end
    $display("[scan] 12/34 frame done, checks so far=%0d", total);
  endtask

  task automatic test_coherence();
    logic [15:0] digs;
    int pc, ix;
    while (t < 4 * FRAME) begin
      if (t == 2 * FRAME + 12) bus.VAL = {7'd56, 7'd78};
      tick();
      total++;
      if ({bus.SEG, bus.DP, bus.AN} !== {exp_seg, exp_dp, exp_an}) begin
        bad++;
        $display("FAIL coherence t=%0d seg/dp/an got=%b/%b/%b want=%b/%b/%b", t_pre, bus.SEG, bus.DP, bus.AN, exp_seg, exp_dp, exp_an);
      end
      pc = t_pre % SD; ix = (t_pre / SD) % ND;
      digs = (t_pre / FRAME == 2) ? 16'h1234 : 16'h5678;
      if (pc >= BC) begin
        total++;
        if (bus.SEG !== dec(int'(digs[ix*4 +: 4]))) begin
          bad++;
          $display("FAIL coherence_digit t=%0d idx=%0d got=%b want=%b", t_pre, ix, bus.SEG, dec(int'(digs[ix*4 +: 4])));
        end
      end
    end
    $display("[coherence] mid-frame change done, checks so far=%0d", total);
  endtask

  task automatic test_boundaries();
    logic [27:0] wseg;
    logic [3:0]  wdp;
    int base, pc, ix;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin bus.VAL = {7'd120, 7'd5};  bus.LZB = 1'b1; wdp = 4'b0100;
                 wseg = {7'b1111110, 7'b1111110, 7'h7F, 7'b0100100}; end
        1: begin bus.VAL = {7'd120, 7'd0};  bus.LZB = 1'b1; wdp = 4'b0100;
                 wseg = {7'b1111110, 7'b1111110, 7'h7F, 7'b0000001}; end
        default: begin bus.VAL = {7'd9, 7'd100}; bus.LZB = 1'b0; wdp = 4'b1001;
                 wseg = {7'b0000001, 7'b0000100, 7'b1111110, 7'b1111110}; end
      endcase
      bus.DP_MASK = wdp;
      base = t / FRAME;
      for (int i = 0; i < 2 * FRAME; i++) begin
        tick();
        total++;
        if ({bus.SEG, bus.DP, bus.AN} !== {exp_seg, exp_dp, exp_an}) begin
          bad++;
          $display("FAIL boundary%0d t=%0d seg/dp/an got=%b/%b/%b want=%b/%b/%b", c, t_pre, bus.SEG, bus.DP, bus.AN, exp_seg, exp_dp, exp_an);
        end
        pc = t_pre % SD; ix = (t_pre / SD) % ND;
        if (t_pre / FRAME == base + 1 && pc >= BC) begin
          total++;
          if ({bus.SEG, bus.DP} !== {wseg[ix*7 +: 7], ~wdp[ix]}) begin
            bad++;
            $display("FAIL boundary%0d_digit idx=%0d seg/dp got=%b/%b want=%b/%b", c, ix, bus.SEG, bus.DP, wseg[ix*7 +: 7], ~wdp[ix]);
          end
        end
      end
      $display("[boundary] case %0d done, checks so far=%0d", c, total);
    end
  endtask

  task automatic test_en_toggle();
    logic [ND-1:0] want_an;
    int pc, ix;
    while (t % SD != 4) begin
      tick();
      total++;
      if ({bus.SEG, bus.DP, bus.AN} !== {exp_seg, exp_dp, exp_an}) begin
        bad++;
        $display("FAIL en_pre t=%0d seg/dp/an got=%b/%b/%b want=%b/%b/%b", t_pre, bus.SEG, bus.DP, bus.AN, exp_seg, exp_dp, exp_an);
      end
    end
    for (int i = 0; i < 9; i++) begin
      bus.EN = (i >= 5);
      tick();
      pc = t_pre % SD; ix = (t_pre / SD) % ND;
      want_an = '1;
      if (i >= 5 && pc >= BC) want_an[ix] = 1'b0;
      total++;
      if ({bus.SEG, bus.DP, bus.AN} !== {exp_seg, exp_dp, exp_an} || bus.AN !== want_an) begin
        bad++;
        $display("FAIL en_toggle t=%0d en=%0b an got=%b want=%b seg/dp got=%b/%b want=%b/%b", t_pre, bus.EN, bus.AN, want_an, bus.SEG, bus.DP, exp_seg, exp_dp);
      end
    end
    $display("[en_toggle] done, checks so far=%0d", total);
  endtask

  task automatic test_blink();
    int base, pc, ix;
    logic want_blank;
    while (t % FRAME != 0) tick();
    bus.VAL = {7'd12, 7'd34}; bus.LZB = 1'b0; bus.DP_MASK = 4'b1111;
`ifdef SEVEN_SEG_BLINK_EN
    bus.BLINK_MASK = 2'b10;
`endif
    base = t / FRAME;
    for (int i = 0; i < 8 * FRAME; i++) begin
      tick();
      total++;
      if ({bus.SEG, bus.DP, bus.AN} !== {exp_seg, exp_dp, exp_an}) begin
        bad++;
        $display("FAIL blink t=%0d seg/dp/an got=%b/%b/%b want=%b/%b/%b", t_pre, bus.SEG, bus.DP, bus.AN, exp_seg, exp_dp, exp_an);
      end
      pc = t_pre % SD; ix = (t_pre / SD) % ND;
`ifdef SEVEN_SEG_BLINK_EN
      want_blank = (ix >= 2) && (((t_pre / FRAME) / BF) % 2 == 1);
`else
      want_blank = 1'b0;
`endif
      if (t_pre / FRAME > base && pc >= BC) begin
        total++;
        if (((bus.SEG === 7'h7F) && (bus.DP === 1'b1)) !== want_blank) begin
          bad++;
          $display("FAIL blink_phase t=%0d idx=%0d seg/dp got=%b/%b want_blank=%0b", t_pre, ix, bus.SEG, bus.DP, want_blank);
        end
      end
    end
    $display("[blink] done, checks so far=%0d", total);
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) begin
        bus.VAL     = {7'($urandom_range(127)), 7'($urandom_range(127))};
        bus.DP_MASK = 4'($urandom);
        bus.LZB     = 1'($urandom);
`ifdef SEVEN_SEG_BLINK_EN
        bus.BLINK_MASK = 2'($urandom);
`endif
      end
      if ($urandom_range(23) == 0) bus.EN = ~bus.EN;
      RST_N = (i == 413) ? 1'b0 : 1'b1;
      tick();
      total++;
      if ({bus.SEG, bus.DP, bus.AN} !== {exp_seg, exp_dp, exp_an}) begin
        bad++;
        $display("FAIL random t=%0d seg/dp/an got=%b/%b/%b want=%b/%b/%b", t_pre, bus.SEG, bus.DP, bus.AN, exp_seg, exp_dp, exp_an);
      end
    end
    RST_N = 1'b1;
    $display("[random] done, checks so far=%0d", total);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_coherence();
    test_boundaries();
    test_en_toggle();
    test_blink();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
